// File: rtl/jt12_pg_ctrl.sv
// Phase-generator control: slot sequencer, per-channel/operator register file,
// stage-aligned parameter delivery and key-on phase-reset handshake.
module jt12_pg_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        wr_freq,
  input  logic [2:0]  wr_ch,
  input  logic [10:0] wr_fnum,
  input  logic [2:0]  wr_block,
  input  logic        wr_opr,
  input  logic [1:0]  wr_op,
  input  logic [3:0]  wr_mul,
  input  logic [2:0]  wr_dt1,
  input  logic        kon_req,
  input  logic [2:0]  kon_ch,
  input  logic [3:0]  kon_mask,
  output logic        kon_busy,
  output logic        kon_done,
  output logic [10:0] fnum_I,
  output logic [2:0]  block_I,
  output logic [2:0]  dt1_II,
  output logic [3:0]  mul_V,
  output logic        pg_rst_III,
  output logic        zero,
  output logic [2:0]  slot_ch,
  output logic [1:0]  slot_op
);

  localparam int unsigned FNUM_W = 11;
  localparam int unsigned BLK_W  = 3;
  localparam int unsigned DT1_W  = 3;
  localparam int unsigned MUL_W  = 4;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned NUM_OP = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } kon_state_e;

  logic [NUM_CH-1:0][FNUM_W-1:0]             fnum_q;
  logic [NUM_CH-1:0][BLK_W-1:0]              block_q;
  logic [NUM_CH-1:0][NUM_OP-1:0][MUL_W-1:0]  mul_q;
  logic [NUM_CH-1:0][NUM_OP-1:0][DT1_W-1:0]  dt1_q;

  logic [CH_W-1:0]   ch_q, ch_nx_c;
  logic [OP_W-1:0]   op_q, op_nx_c;
  logic              zero_q;
  logic [FNUM_W-1:0] fnum_s1_q;
  logic [BLK_W-1:0]  blk_s1_q;
  logic [DT1_W-1:0]  dt1_s2_q;
  logic [MUL_W-1:0]  mul_s2_q, mul_s3_q, mul_s4_q, mul_s5_q;
  logic              rst_s2_q, rst_s3_q;

  kon_state_e        state_q, state_d;
  logic [NUM_OP-1:0] pend_q, pend_d, pend_left;
  logic [CH_W-1:0]   kch_q, kch_d;
  logic              done_q, done_d;
  logic              serve_c;

  // Register file writes are independent of the slot enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      fnum_q  <= '0;
      block_q <= '0;
      mul_q   <= '0;
      dt1_q   <= '0;
    end else begin
      if (wr_freq && (wr_ch < CH_W'(NUM_CH))) begin
        fnum_q[wr_ch]  <= wr_fnum;
        block_q[wr_ch] <= wr_block;
      end
      if (wr_opr && (wr_ch < CH_W'(NUM_CH))) begin
        mul_q[wr_ch][wr_op] <= wr_mul;
        dt1_q[wr_ch][wr_op] <= wr_dt1;
      end
    end
  end

  always_comb begin
    ch_nx_c = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(ch_q + CH_W'(1));
    op_nx_c = (ch_q == CH_W'(NUM_CH - 1)) ? OP_W'(op_q + OP_W'(1)) : op_q;
  end

  assign serve_c = clk_en && (state_q == ST_BUSY) && (ch_q == kch_q) && pend_q[op_q];

  // Slot counter and stage pipeline; stage I reflects the counter itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q      <= '0;
      op_q      <= '0;
      zero_q    <= 1'b1;
      fnum_s1_q <= '0;
      blk_s1_q  <= '0;
      dt1_s2_q  <= '0;
      mul_s2_q  <= '0;
      mul_s3_q  <= '0;
      mul_s4_q  <= '0;
      mul_s5_q  <= '0;
      rst_s2_q  <= 1'b0;
      rst_s3_q  <= 1'b0;
    end else if (clk_en) begin
      ch_q      <= ch_nx_c;
      op_q      <= op_nx_c;
      zero_q    <= (ch_nx_c == '0) && (op_nx_c == '0);
      fnum_s1_q <= fnum_q[ch_nx_c];
      blk_s1_q  <= block_q[ch_nx_c];
      dt1_s2_q  <= dt1_q[ch_q][op_q];
      mul_s2_q  <= mul_q[ch_q][op_q];
      mul_s3_q  <= mul_s2_q;
      mul_s4_q  <= mul_s3_q;
      mul_s5_q  <= mul_s4_q;
      rst_s2_q  <= serve_c;
      rst_s3_q  <= rst_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      kch_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      kch_q   <= kch_d;
      done_q  <= done_d;
    end
  end

  // Key-on handshake: out-of-range channels capture as an empty mask.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    kch_d     = kch_q;
    done_d    = 1'b0;
    pend_left = pend_q;
    if (serve_c) pend_left[op_q] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kon_req) begin
          state_d = ST_BUSY;
          kch_d   = kon_ch;
          pend_d  = (kon_ch < CH_W'(NUM_CH)) ? kon_mask : '0;
        end
      end
      ST_BUSY: begin
        pend_d = pend_left;
        if (pend_left == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign kon_busy   = (state_q == ST_BUSY);
  assign kon_done   = done_q;
  assign fnum_I     = fnum_s1_q;
  assign block_I    = blk_s1_q;
  assign dt1_II     = dt1_s2_q;
  assign mul_V      = mul_s5_q;
  assign pg_rst_III = rst_s3_q;
  assign zero       = zero_q;
  assign slot_ch    = ch_q;
  assign slot_op    = op_q;

endmodule

// File: tb/tb_jt12_pg_ctrl.sv
// Directed self-checking bench for jt12_pg_ctrl; k tracks the expected slot.
module tb_jt12_pg_ctrl;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        wr_freq, wr_opr;
  logic [2:0]  wr_ch, wr_block, wr_dt1;
  logic [10:0] wr_fnum;
  logic [1:0]  wr_op;
  logic [3:0]  wr_mul;
  logic        kon_req;
  logic [2:0]  kon_ch;
  logic [3:0]  kon_mask;
  logic        kon_busy, kon_done;
  logic [10:0] fnum_I;
  logic [2:0]  block_I, dt1_II;
  logic [3:0]  mul_V;
  logic        pg_rst_III, zero;
  logic [2:0]  slot_ch;
  logic [1:0]  slot_op;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  jt12_pg_ctrl dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .wr_freq(wr_freq), .wr_ch(wr_ch), .wr_fnum(wr_fnum), .wr_block(wr_block),
    .wr_opr(wr_opr), .wr_op(wr_op), .wr_mul(wr_mul), .wr_dt1(wr_dt1),
    .kon_req(kon_req), .kon_ch(kon_ch), .kon_mask(kon_mask),
    .kon_busy(kon_busy), .kon_done(kon_done),
    .fnum_I(fnum_I), .block_I(block_I), .dt1_II(dt1_II), .mul_V(mul_V),
    .pg_rst_III(pg_rst_III), .zero(zero), .slot_ch(slot_ch), .slot_op(slot_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic en, r;
    en = clk_en;
    r  = rst;
    @(posedge clk);
    @(negedge clk);
    if (r) k = 0;
    else if (en) k++;
  endtask

  function automatic int cur_ch();
    return k % 6;
  endfunction

  function automatic int cur_op();
    return (k / 6) % 4;
  endfunction

  task automatic check_slot(input string tag);
    logic [5:0] e;
    e = {1'((k % 24) == 0), 2'(cur_op()), 3'(cur_ch())};
    check(tag, {zero, slot_op, slot_ch}, e);
  endtask

  task automatic goto_slot(input int c, input int o);
    for (int i = 0; i < 24; i++) begin
      if (cur_ch() == c && cur_op() == o) break;
      clk_en = 1'b1;
      step();
    end
  endtask

  function automatic logic [10:0] exp_fnum(input int c);
    case (c)
      3:       return 11'h111;
      5:       return 11'h123;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [2:0] exp_blk(input int c);
    case (c)
      3:       return 3'd1;
      5:       return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  initial begin
    int zcnt, e;
    logic seen_pg, seen_done, seen_data;
    rst = 1'b1; clk_en = 1'b0;
    wr_freq = 1'b0; wr_opr = 1'b0; wr_ch = '0; wr_fnum = '0; wr_block = '0;
    wr_op = '0; wr_mul = '0; wr_dt1 = '0;
    kon_req = 1'b0; kon_ch = '0; kon_mask = '0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check_slot("rst_slot");
    check("rst_fnum", fnum_I, 0);
    check("rst_blk", block_I, 0);
    check("rst_dt1", dt1_II, 0);
    check("rst_mul", mul_V, 0);
    check("rst_pg", pg_rst_III, 0);
    check("rst_busy", kon_busy, 0);
    check("rst_done", kon_done, 0);

    // Slot sequence over two full rotations
    zcnt = 0;
    clk_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      check_slot("seq_slot");
      if (zero) zcnt++;
    end
    check("seq_zero_count", zcnt, 2);

    // Register writes with clk_en low; outputs must hold
    clk_en = 1'b0;
    wr_freq = 1'b1; wr_opr = 1'b1; wr_ch = 3'd3; wr_fnum = 11'h2A5; wr_block = 3'd4;
    wr_op = 2'd2; wr_mul = 4'd7; wr_dt1 = 3'd5;
    step();
    wr_ch = 3'd5; wr_opr = 1'b0; wr_fnum = 11'h123; wr_block = 3'd7;
    step();
    wr_opr = 1'b1; wr_ch = 3'd6; wr_fnum = 11'h7FF; wr_block = 3'd7; wr_op = 2'd0;
    wr_mul = 4'hF; wr_dt1 = 3'd7;
    step();
    wr_ch = 3'd7;
    step();
    wr_freq = 1'b0; wr_opr = 1'b0;
    check_slot("hold_slot");
    check("hold_fnum", fnum_I, 0);

    goto_slot(3, 1);
    check("fnum_31", fnum_I, 11'h2A5);
    check("blk_31", block_I, 3'd4);
    step();
    check("dt1_after_31", dt1_II, 0);
    check("fnum_41", fnum_I, 0);
    goto_slot(3, 2);
    check("fnum_32", fnum_I, 11'h2A5);
    check("blk_32", block_I, 3'd4);
    step();
    check("dt1_after_32", dt1_II, 3'd5);
    step();
    check("fnum_52", fnum_I, 11'h123);
    check("blk_52", block_I, 3'd7);
    check("dt1_after_42", dt1_II, 0);
    step();
    check("mul_lat3", mul_V, 0);
    step();
    check("mul_lat4", mul_V, 4'd7);
    step();
    check("mul_lat5", mul_V, 0);

    // Write on the fetch edge: old value is presented first
    goto_slot(2, 0);
    wr_freq = 1'b1; wr_ch = 3'd3; wr_fnum = 11'h111; wr_block = 3'd1;
    step();
    wr_freq = 1'b0;
    check("fetch_old_fnum", fnum_I, 11'h2A5);
    check("fetch_old_blk", block_I, 3'd4);
    goto_slot(3, 1);
    check("fetch_new_fnum", fnum_I, 11'h111);
    check("fetch_new_blk", block_I, 3'd1);

    // Key-on ch1 mask 1010 captured at slot (0,0); a second request while busy
    goto_slot(0, 0);
    kon_req = 1'b1; kon_ch = 3'd1; kon_mask = 4'b1010;
    step();
    kon_req = 1'b0;
    check("kon_busy_cap", kon_busy, 1);
    check("kon_done_cap", kon_done, 0);
    for (int n = 1; n <= 26; n++) begin
      kon_req = (n == 4);
      kon_mask = (n == 4) ? 4'b0101 : 4'b1010;
      step();
      kon_req = 1'b0;
      e = 1 + n;
      check("kon_pg", pg_rst_III, (e == 9 || e == 21));
      check("kon_done", kon_done, (e == 20));
      check("kon_busy", kon_busy, (e < 20));
    end

    // Empty mask with clk_en low
    clk_en = 1'b0;
    kon_req = 1'b1; kon_ch = 3'd2; kon_mask = 4'b0000;
    step();
    kon_req = 1'b0;
    check("empty_busy1", kon_busy, 1);
    check("empty_done1", kon_done, 0);
    step();
    check("empty_done2", kon_done, 1);
    check("empty_busy2", kon_busy, 0);
    check_slot("empty_slot_hold");
    step();
    check("empty_done3", kon_done, 0);

    // Out-of-range channel
    clk_en = 1'b1;
    kon_req = 1'b1; kon_ch = 3'd7; kon_mask = 4'b1111;
    step();
    kon_req = 1'b0;
    check("ch7_busy1", kon_busy, 1);
    step();
    check("ch7_done", kon_done, 1);
    check("ch7_busy2", kon_busy, 0);
    seen_pg = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen_pg |= pg_rst_III;
    end
    check("ch7_no_pg", seen_pg, 0);

    // Capture coinciding with the target slot waits a full rotation
    goto_slot(2, 0);
    kon_req = 1'b1; kon_ch = 3'd2; kon_mask = 4'b0001;
    step();
    kon_req = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      step();
      check("worst_pg", pg_rst_III, (n == 25));
      check("worst_done", kon_done, (n == 24));
      check("worst_busy", kon_busy, (n < 24));
    end

    // clk_en one cycle in three
    for (int c = 0; c < 78; c++) begin
      clk_en = ((c % 3) == 0);
      step();
      check_slot("slow_slot");
      check("slow_fnum", fnum_I, exp_fnum(cur_ch()));
      check("slow_blk", block_I, exp_blk(cur_ch()));
      check("slow_dt1", dt1_II, (cur_ch() == 4 && cur_op() == 2) ? 3'd5 : 3'd0);
      check("slow_mul", mul_V, (cur_ch() == 1 && cur_op() == 3) ? 4'd7 : 4'd0);
    end

    // Reset in the middle of a key-on
    goto_slot(0, 0);
    kon_req = 1'b1; kon_ch = 3'd4; kon_mask = 4'b1111;
    step();
    kon_req = 1'b0;
    step(); step(); step();
    check("mid_busy", kon_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", kon_busy, 0);
    check("mid_rst_done", kon_done, 0);
    check_slot("mid_rst_slot");
    check("mid_rst_pg", pg_rst_III, 0);
    seen_pg = 1'b0; seen_done = 1'b0; seen_data = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      seen_pg   |= pg_rst_III;
      seen_done |= kon_done | kon_busy;
      seen_data |= (fnum_I != 0) || (block_I != 0) || (dt1_II != 0) || (mul_V != 0);
    end
    check("post_rst_pg", seen_pg, 0);
    check("post_rst_kon", seen_done, 0);
    check("post_rst_data", seen_data, 0);
    check_slot("post_rst_slot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
